// File: rtl/fetch_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit_if : memory, redirect and decode-handshake bundle of fetch_unit
// Revision      : 1.0
// ----------------------------------------------------------------------------
interface fetch_unit_if;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        fault_o;

   modport master (
      output imem_addr_o,
      input  imem_instr_i,
      input  redirect_valid_i,
      input  redirect_pc_i,
      output instr_valid_o,
      input  instr_ready_i,
      output instr_o,
      output pc_o,
      output fault_o
   );

   modport slave (
      input  imem_addr_o,
      output imem_instr_i,
      output redirect_valid_i,
      output redirect_pc_i,
      input  instr_valid_o,
      output instr_ready_i,
      input  instr_o,
      input  pc_o,
      input  fault_o
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_unit : fetch PC, prefetch FIFO and redirect/flush for a comb. ROM
// Revision   : 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  wire logic    clk_i,
   input  wire logic    rst_i,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        halted_q, halted_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   logic [31:0] pc_mem_q    [FIFO_DEPTH];
   logic [31:0] instr_mem_q [FIFO_DEPTH];
   logic        fault_mem_q [FIFO_DEPTH];

   logic        empty, full, pop, push, misaligned;
   logic [31:0] push_instr;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop        = !empty && bus.instr_ready_i;
   assign push       = !bus.redirect_valid_i && !halted_q && (!full || pop);
   assign misaligned = (fetch_pc_q[1:0] != 2'b00);
   assign push_instr = misaligned ? NOP_INSTR : bus.imem_instr_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (bus.redirect_valid_i) begin
         // Flush discards any in-flight handshake along with the rest of the FIFO.
         fetch_pc_d = bus.redirect_pc_i;
         halted_d   = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (misaligned) begin
               halted_d = 1'b1;
            end else begin
               fetch_pc_d = fetch_pc_q + 32'd4;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible through non-empty pointers.
   always_ff @(posedge clk_i) begin
      if (!rst_i && push) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q[AW-1:0]] <= push_instr;
         fault_mem_q[wr_ptr_q[AW-1:0]] <= misaligned;
      end
   end

   assign bus.imem_addr_o   = fetch_pc_q;
   assign bus.instr_valid_o = !empty;
   assign bus.instr_o       = empty ? 32'h0 : instr_mem_q[rd_ptr_q[AW-1:0]];
   assign bus.pc_o          = empty ? 32'h0 : pc_mem_q[rd_ptr_q[AW-1:0]];
   assign bus.fault_o       = empty ? 1'b0  : fault_mem_q[rd_ptr_q[AW-1:0]];
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_unit : directed bench for fetch_unit against a small ROM model
// Revision      : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2),
      .NOP_INSTR  (32'h0000_0013)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h00: return 32'h0040_2103;
         32'h04: return 32'h0040_0183;
         32'h08: return 32'h0040_1203;
         32'h0C: return 32'h0220_0023;
         32'h18: return 32'h5555_5637;
         32'h1C: return 32'h0000_1317;
         default: return 32'h0;
      endcase
   endfunction

   always_comb bus.imem_instr_i = rom_word(bus.imem_addr_o);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [31:0] p, input logic [31:0] i,
                       input logic f);
      chk({tag, "_valid"}, {31'b0, bus.instr_valid_o}, 32'd1);
      chk({tag, "_pc"}, bus.pc_o, p);
      chk({tag, "_instr"}, bus.instr_o, i);
      chk({tag, "_fault"}, {31'b0, bus.fault_o}, {31'b0, f});
   endtask

   task automatic idle(input string tag, input logic [31:0] addr);
      chk({tag, "_valid"}, {31'b0, bus.instr_valid_o}, 32'd0);
      chk({tag, "_addr"}, bus.imem_addr_o, addr);
   endtask

   task automatic do_reset(input logic rdy);
      rst = 1'b1;
      bus.redirect_valid_i = 1'b0;
      bus.instr_ready_i    = rdy;
      step();
      rst = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = target;
      step();
      bus.redirect_valid_i = 1'b0;
   endtask

   initial begin
      bus.redirect_valid_i = 1'b0;
      bus.redirect_pc_i    = 32'h0;
      bus.instr_ready_i    = 1'b0;

      // 1: streaming after reset
      do_reset(1'b1);
      idle("rst", 32'h0);
      chk("rst_instr", bus.instr_o, 32'h0);
      chk("rst_pc", bus.pc_o, 32'h0);
      chk("rst_fault", {31'b0, bus.fault_o}, 32'd0);
      step(); head("s0", 32'h00, 32'h0040_2103, 1'b0);
      step(); head("s1", 32'h04, 32'h0040_0183, 1'b0);
      step(); head("s2", 32'h08, 32'h0040_1203, 1'b0);
      step(); head("s3", 32'h0C, 32'h0220_0023, 1'b0);

      // 2: backpressure fills the FIFO and stalls the fetch PC
      do_reset(1'b0);
      for (int k = 0; k < 5; k++) step();
      head("bp_hold", 32'h00, 32'h0040_2103, 1'b0);
      chk("bp_addr", bus.imem_addr_o, 32'h08);
      bus.instr_ready_i = 1'b1;
      step(); head("bp1", 32'h04, 32'h0040_0183, 1'b0);
      step(); head("bp2", 32'h08, 32'h0040_1203, 1'b0);
      step(); head("bp3", 32'h0C, 32'h0220_0023, 1'b0);

      // 3: redirect while full, with a handshake in the same cycle
      do_reset(1'b0);
      step(); step();
      chk("full_addr", bus.imem_addr_o, 32'h08);
      bus.instr_ready_i = 1'b1;
      redirect(32'h18);
      idle("rd18", 32'h18);
      step(); head("t18", 32'h18, 32'h5555_5637, 1'b0);
      step(); head("t1c", 32'h1C, 32'h0000_1317, 1'b0);

      // 4: misaligned target produces one fault entry then halts
      redirect(32'h1A);
      idle("rd1a", 32'h1A);
      step(); head("f1a", 32'h1A, 32'h0000_0013, 1'b1);
      chk("f1a_addr", bus.imem_addr_o, 32'h1A);
      step(); idle("halt0", 32'h1A);
      step(); step(); step();
      idle("halt3", 32'h1A);
      redirect(32'h0);
      idle("rd0", 32'h0);
      step(); head("resume", 32'h00, 32'h0040_2103, 1'b0);

      // 5: PC wraps past the top of the address space
      redirect(32'hFFFF_FFFC);
      idle("rdtop", 32'hFFFF_FFFC);
      step(); head("top", 32'hFFFF_FFFC, 32'h0, 1'b0);
      chk("wrap_addr", bus.imem_addr_o, 32'h0);
      step(); head("wrap", 32'h00, 32'h0040_2103, 1'b0);

      // 6: reset beats a pending redirect and handshake on a full FIFO
      bus.instr_ready_i = 1'b0;
      step(); step();
      chk("pre_valid", {31'b0, bus.instr_valid_o}, 32'd1);
      rst = 1'b1;
      bus.redirect_valid_i = 1'b1;
      bus.redirect_pc_i    = 32'h18;
      bus.instr_ready_i    = 1'b1;
      step();
      rst = 1'b0;
      bus.redirect_valid_i = 1'b0;
      bus.instr_ready_i    = 1'b0;
      idle("mrst", 32'h0);
      chk("mrst_instr", bus.instr_o, 32'h0);
      chk("mrst_pc", bus.pc_o, 32'h0);
      chk("mrst_fault", {31'b0, bus.fault_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
